grf_scoreboard: RTL
===================

# grf_scoreboard

Register-file write-tracking scoreboard for the pipelined MIPS core. It records every destination register issued from the D stage but not yet written back to the GRF. It stalls any issue that would read a pending register, except where the GRF's internal write-through already covers the read. It sits beside the GRF, fed by the D-stage decode (issue side) and the W-stage writeback (retire side).

## Interface

- `MAX_PENDING`, default 3: maximum outstanding writes per register (E, M, W in flight); counter width is 2 bits.
- `clk` input, 1: clock; all state updates on the rising edge.
- `reset` input, 1: synchronous, active-high; clears all state.
- `issue_valid` input, 1: D stage presents an instruction this cycle.
- `issue_rs` input, 5: first source register.
- `issue_rt` input, 5: second source register.
- `issue_use_rs` input, 1: the instruction reads rs.
- `issue_use_rt` input, 1: the instruction reads rt.
- `issue_rd` input, 5: destination register; 0 means no write.
- `wb_valid` input, 1: the W stage writes the GRF this cycle.
- `wb_addr` input, 5: GRF write address (A3).
- `flush` input, 1: all in-flight instructions are killed.
- `stall` output, 1: combinational; the issue is refused this cycle.
- `pending_mask` output, 32: registered; bit r = (count[r] != 0); bit 0 is always 0.
- `inflight` output, 7: registered total of all counts (0..93).
- `err_underflow` output, 1: registered, sticky; set when a writeback arrives with no matching pending write.

## Operation

- State: count[r] (2 bits) for r = 1..31. Register 0 is never tracked, never stalls and never counts.
- wb_hit(r) = wb_valid && wb_addr == r && r != 0.
- pending_eff(r) = count[r] != 0 && !(wb_hit(r) && count[r] == 1). A sole pending write retiring this cycle is bypassed by the GRF, so it does not stall.
- stall = issue_valid && !flush && (src_hazard || dst_full).
  - src_hazard: (issue_use_rs && rs != 0 && pending_eff(rs)) || (issue_use_rt && rt != 0 && pending_eff(rt)).
  - dst_full: issue_rd != 0 && count[rd] == MAX_PENDING && !wb_hit(rd).
- accept = issue_valid && !stall && !flush.
- Count update for each r: next = count + (accept && issue_rd == r) − (wb_hit(r) && count[r] != 0).
  - Simultaneous issue and writeback to the same register leave the count unchanged.
- Underflow: wb_hit(r) with count[r] == 0 sets err_underflow; the count stays 0.
- WAW is permitted; the pipeline is in-order, so writebacks retire in issue order.
- flush has priority over everything except reset. On the next edge all counts are 0, and any issue or writeback in that cycle is ignored. err_underflow is not cleared by flush.
- inflight_next = sum of next counts. It is kept as a running register: +1 on accept with rd != 0, −1 on a non-underflow wb_hit, 0 on flush or reset.

## Timing

- Reset (synchronous): on the edge with reset=1, all counts, pending_mask, inflight and err_underflow go to 0. While reset is high, stall = 0 and issue/writeback are ignored.
- stall reflects current state and same-cycle inputs with zero-cycle latency.
- Issue-to-pending latency is 1 edge. A dependent reader in the next cycle sees the stall.
- Writeback-to-clear latency: the same cycle through pending_eff; the count clears on the following edge.
- pending_mask and inflight change only on clock edges.
- Reset asserted mid-operation discards all pending state. The bench must not expect the writebacks issued before reset to underflow-check afterwards; they will set err_underflow if they still arrive.

## Test plan

- Reset, then issue rd=8, then next cycle issue use_rs rs=8 → stall=1; pending_mask=0x100; inflight=1.
- Pending $8 count=1. Issue reads rs=8 in the same cycle as wb_valid wb_addr=8 → stall=0 and the issue is accepted. If that issue has rd=9, next pending_mask=0x200.
- Issue rd=5 three times with no writeback → count[5]=3 and inflight=3. A fourth issue rd=5 gives stall=1. The same fourth issue with wb_hit(5) gives stall=0, and count stays 3.
- Issue rs=0/rt=0 with use bits set, and rd=0 → never stalls, pending_mask stays 0.
- wb_valid wb_addr=12 with count[12]=0 → err_underflow=1 after the edge; it stays 1 through flush and clears only on reset.
- With counts pending on $3 and $4, assert flush alongside issue rd=6 and wb to $3 → next cycle pending_mask=0 and inflight=0; the issue is not recorded.

Source files
------------

// File: rtl/grf_scoreboard.sv
// grf_scoreboard: tracks destination registers issued from D but not yet
// written back to the GRF, and stalls issues that would read a pending value
// (unless the GRF write-through covers it) or overflow a register's counter.
module grf_scoreboard #(
  parameter int unsigned MAX_PENDING = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic        issue_use_rs,
  input  logic        issue_use_rt,
  input  logic [4:0]  issue_rd,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] pending_mask,
  output logic [6:0]  inflight,
  output logic        err_underflow
);

  localparam int unsigned NREG  = 32;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned INF_W = 7;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  mask_q, mask_d;
  logic [INF_W-1:0] inflight_q, inflight_d;
  logic             err_q, err_d;

  logic wb_hit_rs_c, wb_hit_rt_c, wb_hit_rd_c;
  logic pend_rs_c, pend_rt_c;
  logic src_hazard_c, dst_full_c, stall_c, accept_c;
  logic wb_dec_c, wb_under_c, inc_c;

  // Hazard detection against current counts and same-cycle writeback.
  always_comb begin
    wb_hit_rs_c  = wb_valid && (wb_addr == issue_rs) && (issue_rs != 5'd0);
    wb_hit_rt_c  = wb_valid && (wb_addr == issue_rt) && (issue_rt != 5'd0);
    wb_hit_rd_c  = wb_valid && (wb_addr == issue_rd) && (issue_rd != 5'd0);
    // A sole pending write retiring now is forwarded by the GRF write-through.
    pend_rs_c    = (cnt_q[issue_rs] != CNT_W'(0)) &&
                   !(wb_hit_rs_c && (cnt_q[issue_rs] == CNT_W'(1)));
    pend_rt_c    = (cnt_q[issue_rt] != CNT_W'(0)) &&
                   !(wb_hit_rt_c && (cnt_q[issue_rt] == CNT_W'(1)));
    src_hazard_c = (issue_use_rs && (issue_rs != 5'd0) && pend_rs_c) ||
                   (issue_use_rt && (issue_rt != 5'd0) && pend_rt_c);
    dst_full_c   = (issue_rd != 5'd0) &&
                   (cnt_q[issue_rd] == CNT_W'(MAX_PENDING)) && !wb_hit_rd_c;
    stall_c      = !reset && issue_valid && !flush && (src_hazard_c || dst_full_c);
    accept_c     = !reset && issue_valid && !flush && !stall_c;
    inc_c        = accept_c && (issue_rd != 5'd0);
    wb_dec_c     = wb_valid && (wb_addr != 5'd0) && (cnt_q[wb_addr] != CNT_W'(0));
    wb_under_c   = wb_valid && (wb_addr != 5'd0) && (cnt_q[wb_addr] == CNT_W'(0));
  end

  assign stall = stall_c;

  // Next-state counts, pending mask, running in-flight total and sticky error.
  always_comb begin
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    inflight_d = inflight_q;
    err_d      = err_q;
    if (flush) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_d[r] = CNT_W'(0);
      end
      mask_d     = '0;
      inflight_d = INF_W'(0);
    end else begin
      cnt_d[0]  = CNT_W'(0);
      mask_d[0] = 1'b0;
      for (int r = 1; r < NREG; r++) begin
        cnt_d[r]  = cnt_q[r]
                  + CNT_W'(accept_c && (issue_rd == 5'(r)))
                  - CNT_W'(wb_valid && (wb_addr == 5'(r)) && (cnt_q[r] != CNT_W'(0)));
        mask_d[r] = (cnt_d[r] != CNT_W'(0));
      end
      inflight_d = inflight_q + INF_W'(inc_c) - INF_W'(wb_dec_c);
      err_d      = err_q | wb_under_c;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= CNT_W'(0);
      end
      mask_q     <= '0;
      inflight_q <= INF_W'(0);
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign pending_mask  = mask_q;
  assign inflight      = inflight_q;
  assign err_underflow = err_q;

endmodule
